// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the matrix-mult buffer memory arbiters.
package matrix_mult_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_CORE, ARB_HOST} mem_arb_state_e;

    localparam int unsigned MEM_ARB_MAX_BURST = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Burst-locked core/host arbiter in front of one single-port buffer SRAM.
// Optional per-grant access cap: define MEM_ARB_BURST_LIMIT_EN.
module mem_port_arbiter
    import matrix_mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SIZE       = 256,
    parameter int unsigned MAX_BURST  = MEM_ARB_MAX_BURST
) (
    input  logic                    clk_i,
    input  logic                    rstn_async_i,

    input  logic                    core_req_i,
    input  logic                    core_wenb_i,
    input  logic [$clog2(SIZE)-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_d_i,
    input  logic                    core_last_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,

    input  logic                    host_req_i,
    input  logic                    host_wenb_i,
    input  logic [$clog2(SIZE)-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0]   host_d_i,
    input  logic                    host_last_i,
    output logic                    host_gnt_o,
    output logic                    host_rvalid_o,

    output logic [DATA_WIDTH-1:0]   q_o,

    output logic                    mem_cenb_o,
    output logic                    mem_wenb_o,
    output logic [$clog2(SIZE)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_d_o,
    input  logic [DATA_WIDTH-1:0]   mem_q_i
);

    if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("mem_port_arbiter: MAX_BURST must be in 2..256");
    end

    mem_arb_state_e state_q, state_d;
    logic           last_host_q, last_host_d;
    logic           core_rv_q, core_rv_d;
    logic           host_rv_q, host_rv_d;

    logic core_issue;
    logic host_issue;
    logic issue;
    logic force_release;
    logic release_grant;

    assign core_issue = (state_q == ARB_CORE) && core_req_i;
    assign host_issue = (state_q == ARB_HOST) && host_req_i;
    assign issue      = core_issue || host_issue;

    assign core_gnt_o    = (state_q == ARB_CORE);
    assign host_gnt_o    = (state_q == ARB_HOST);
    assign core_rvalid_o = core_rv_q;
    assign host_rvalid_o = host_rv_q;
    assign q_o           = mem_q_i;

    always_comb begin
        mem_cenb_o = !issue;
        mem_wenb_o = 1'b1;
        mem_addr_o = '0;
        mem_d_o    = '0;
        if (core_issue) begin
            mem_wenb_o = core_wenb_i;
            mem_addr_o = core_addr_i;
            mem_d_o    = core_d_i;
        end else if (host_issue) begin
            mem_wenb_o = host_wenb_i;
            mem_addr_o = host_addr_i;
            mem_d_o    = host_d_i;
        end
    end

    always_comb begin
        release_grant = (core_issue && core_last_i) || (host_issue && host_last_i)
                        || force_release;
        state_d     = state_q;
        last_host_d = last_host_q;
        case (state_q)
            ARB_IDLE: begin
                if (core_req_i && host_req_i) begin
                    state_d = last_host_q ? ARB_CORE : ARB_HOST;
                end else if (core_req_i) begin
                    state_d = ARB_CORE;
                end else if (host_req_i) begin
                    state_d = ARB_HOST;
                end
            end
            ARB_CORE: begin
                if (release_grant) begin
                    last_host_d = 1'b0;
                    state_d     = host_req_i ? ARB_HOST : ARB_IDLE;
                end
            end
            ARB_HOST: begin
                if (release_grant) begin
                    last_host_d = 1'b1;
                    state_d     = core_req_i ? ARB_CORE : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // Read tag follows the issuing owner, so it survives a same-cycle handover.
        core_rv_d = core_issue && core_wenb_i;
        host_rv_d = host_issue && host_wenb_i;
    end

    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            state_q     <= ARB_IDLE;
            last_host_q <= 1'b1;
            core_rv_q   <= 1'b0;
            host_rv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_host_q <= last_host_d;
            core_rv_q   <= core_rv_d;
            host_rv_q   <= host_rv_d;
        end
    end

`ifdef MEM_ARB_BURST_LIMIT_EN
    localparam int unsigned CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    // Counter sits at MAX_BURST-1 while the cap-th access issues.
    assign force_release = (burst_cnt_q == CNT_MAX) &&
                           ((core_issue && host_req_i) || (host_issue && core_req_i));

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_d != state_q) begin
            burst_cnt_d = '0;
        end else if (issue && (burst_cnt_q != CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign force_release = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural SRAM behind it.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 0, c_wenb = 1, c_last = 0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_d = '0;
    logic          h_req = 0, h_wenb = 1, h_last = 0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_d = '0;
    logic          core_gnt_o, core_rvalid_o, host_gnt_o, host_rvalid_o;
    logic [DW-1:0] q_o, mem_d_o, mem_q_r;
    logic          mem_cenb_o, mem_wenb_o;
    logic [AW-1:0] mem_addr_o;

    mem_port_arbiter #(.DATA_WIDTH(DW), .SIZE(256), .MAX_BURST(4)) dut (
        .clk_i(clk), .rstn_async_i(rst_n),
        .core_req_i(c_req), .core_wenb_i(c_wenb), .core_addr_i(c_addr),
        .core_d_i(c_d), .core_last_i(c_last), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .host_req_i(h_req), .host_wenb_i(h_wenb), .host_addr_i(h_addr),
        .host_d_i(h_d), .host_last_i(h_last), .host_gnt_o(host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .q_o(q_o),
        .mem_cenb_o(mem_cenb_o), .mem_wenb_o(mem_wenb_o), .mem_addr_o(mem_addr_o),
        .mem_d_o(mem_d_o), .mem_q_i(mem_q_r)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram    [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (!mem_cenb_o) begin
            if (!mem_wenb_o) sram[mem_addr_o] <= mem_d_o;
            else             mem_q_r <= sram[mem_addr_o];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            host;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit            exp_c, exp_h;
        logic [DW-1:0] exp_q;
        sb_t           e;
        exp_c = 0;
        exp_h = 0;
        exp_q = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e     = sb.pop_front();
            exp_c = !e.host;
            exp_h = e.host;
            exp_q = e.data;
        end
        if (exp_c || exp_h || core_rvalid_o || host_rvalid_o) begin
            check_eq("core_rvalid", core_rvalid_o, exp_c);
            check_eq("host_rvalid", host_rvalid_o, exp_h);
            if (exp_c || exp_h) check_eq("q_o", q_o, exp_q);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input bit ec, input bit eh);
        logic          ic, ih, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        ic = ec && c_req;
        ih = eh && h_req;
        check_eq("core_gnt", core_gnt_o, ec);
        check_eq("host_gnt", host_gnt_o, eh);
        check_eq("mem_cenb", mem_cenb_o, !(ic || ih));
        if (ic || ih) begin
            w = ic ? c_wenb : h_wenb;
            a = ic ? c_addr : h_addr;
            d = ic ? c_d : h_d;
            check_eq("mem_wenb", mem_wenb_o, w);
            check_eq("mem_addr", mem_addr_o, a);
            if (!w) begin
                check_eq("mem_d", mem_d_o, d);
                ref_mem[a] = d;
            end else begin
                sb.push_back('{ih, ref_mem[a], cyc + 1});
            end
        end else begin
            check_eq("idle_wenb", mem_wenb_o, 1'b1);
            check_eq("idle_addr", mem_addr_o, '0);
            check_eq("idle_d", mem_d_o, '0);
        end
    endtask

    initial begin
        int ci;
        bit hdone, ec, eh;

        repeat (2) @(negedge clk);
        check_eq("rst_core_gnt", core_gnt_o, 0);
        check_eq("rst_host_gnt", host_gnt_o, 0);
        check_eq("rst_core_rv", core_rvalid_o, 0);
        check_eq("rst_host_rv", host_rvalid_o, 0);
        check_eq("rst_cenb", mem_cenb_o, 1);
        check_eq("rst_wenb", mem_wenb_o, 1);
        check_eq("rst_addr", mem_addr_o, '0);
        check_eq("rst_d", mem_d_o, '0);
        rst_n = 1'b1;

        // Tie after reset: core first, write burst 0..3, host follows with no bubble.
        tick();
        c_req = 1; c_wenb = 0; c_addr = 0; c_d = {32'hC0DE0000, 32'd0}; c_last = 0;
        h_req = 1; h_wenb = 0; h_addr = 7; h_d = 64'h0000_0000_DEAD_BEEF; h_last = 1;
        expect_cycle(0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            c_addr = AW'(k); c_d = {32'hC0DE0000, 32'(k)}; c_last = (k == 3);
            expect_cycle(1, 0);
        end
        tick(); c_req = 0;
        expect_cycle(0, 1);
        tick(); h_wenb = 1; h_addr = 7;
        expect_cycle(0, 0);
        tick();
        expect_cycle(0, 1);
        tick(); h_req = 0;
        expect_cycle(0, 0);

        // Stall: core drops req for 3 cycles while host waits.
        tick(); c_req = 1; c_wenb = 0; c_addr = 10; c_d = 64'h1010_1010_AAAA_5555; c_last = 0;
        expect_cycle(0, 0);
        tick();
        expect_cycle(1, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); c_req = 0; h_req = 1; h_wenb = 1; h_addr = 10; h_last = 1;
            expect_cycle(1, 0);
        end
        tick(); c_req = 1; c_addr = 11; c_d = 64'h1111_2222_3333_4444; c_last = 1;
        expect_cycle(1, 0);
        tick(); c_wenb = 1; c_addr = 2; c_last = 1;
        expect_cycle(0, 1);
        tick(); h_req = 0;
        expect_cycle(1, 0);
        tick(); c_req = 0;
        expect_cycle(0, 0);

        // Ten-access core stream with host contending.
        ci = 0;
        hdone = 0;
        for (int t = 0; t <= 12; t++) begin
            tick();
            c_req = (ci < 10); c_wenb = 0; c_addr = AW'(20 + ci);
            c_d = {32'hB0B0B0B0, 32'(ci)}; c_last = (ci == 9);
            h_req = (t >= 1) && !hdone; h_wenb = 1; h_addr = 20; h_last = 1;
`ifdef MEM_ARB_BURST_LIMIT_EN
            ec = (t >= 1 && t <= 4) || (t >= 6 && t <= 11);
            eh = (t == 5);
`else
            ec = (t >= 1 && t <= 10);
            eh = (t == 11);
`endif
            expect_cycle(ec, eh);
            if (ec) ci++;
            if (eh) hdone = 1;
        end
        check_eq("burst_count", 32'(ci), 32'd10);
        tick(); c_req = 0; h_req = 0;
        expect_cycle(0, 0);

        // Reset while a host read is being issued.
        tick(); h_req = 1; h_wenb = 1; h_addr = 7; h_last = 1;
        expect_cycle(0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_cenb", mem_cenb_o, 1);
        check_eq("rstmid_host_gnt", host_gnt_o, 0);
        check_eq("rstmid_wenb", mem_wenb_o, 1);
        tick(); h_req = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_cycle(0, 0);
            check_eq("post_rst_host_rv", host_rvalid_o, 0);
        end

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
